axi_freq_selector_mc: RTL and testbench
=======================================

Name: axi_freq_selector_mc

Overview:
- Parametrised multi-lane successor of the single-channel frequency selector.
- Holds a table of tone indices, written over AXI4-Lite.
- On each rd_en_ring strobe, emits the next group of LANES indices to the tone generator, in ring mode or single-pass mode.
- Single clock domain: the AXI clock also drives the readout side, so there is no CDC inside the block.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width (fixed at 32).
- C_S_AXI_ADDR_WIDTH, 5, AXI4-Lite byte address width (8 registers).
- IDX_W, 14, width of one tone index.
- LANES, 2, indices emitted per strobe (1..8).
- DEPTH, 256, number of groups held in the table (power of 2).

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- rd_en_ring  in  1  advance strobe, one group per asserted cycle.
- dout  out  LANES*IDX_W  current group; lane k occupies bits [k*IDX_W +: IDX_W].
- dout_valid  out  1  one-cycle pulse marking new dout.
- dout_mon  out  IDX_W  copy of lane 0 of dout.
- wrap  out  1  one-cycle pulse when the last group is served in ring mode.
- done  out  1  level; single-pass has finished.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY/WDATA/WSTRB/WVALID/WREADY/BRESP/BVALID/BREADY/ARADDR/ARPROT/ARVALID/ARREADY/RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite slave, widths per parameters.

Behaviour:
- Reset is asynchronous and active-low. While S_AXI_ARESETN=0:
  - dout=0, dout_valid=0, wrap=0, done=0.
  - All AXI ready/valid outputs are 0.
  - CTRL=0, LENGTH=DEPTH, WADDR=0, read pointer rptr=0.
  - The table RAM is not reset; its contents are undefined.
- Registers (byte offsets):
  - 0x00 CTRL. bit0 EN. bit1 MODE (0=ring, 1=single-pass). bit2 CLR, self-clearing: write 1 → rptr=0 and done=0 next cycle; always reads 0.
  - 0x04 LENGTH: active groups. 0 is treated as 1; values above DEPTH are clamped to DEPTH.
  - 0x08 WADDR: flat entry address = group*LANES + lane.
  - 0x0C WDATA: bits [IDX_W-1:0] are written to table[WADDR]; WADDR then increments, wrapping to 0 after DEPTH*LANES-1. Reads return 0.
  - 0x10 STATUS (read-only): bit0 running (EN & ~done), bit1 done, bits [31:16] rptr.
  - Unmapped offsets: writes are ignored and reads return 0. BRESP and RRESP are always OKAY.
- AXI write: accepted only when AWVALID & WVALID are both high. AWREADY and WREADY pulse together for one cycle. BVALID is asserted the next cycle and held until BREADY. No new write is accepted while BVALID=1. WSTRB is honoured per byte on CTRL, LENGTH and WADDR; a WDATA write requires WSTRB[1:0]=11, otherwise it is dropped and WADDR does not increment.
- AXI read: ARREADY pulses for one cycle. RDATA/RVALID follow the next cycle and are held until RREADY.
- Readout (a strobe is serviced when rd_en_ring=1, EN=1, done=0, and no CLR is active that cycle):
  - Cycle N: rd_en_ring is sampled.
  - Cycle N+1: dout = table group rptr, dout_valid=1, and rptr advances.
  - Throughput is one group per cycle; back-to-back strobes are supported.
- Wrap and termination at rptr = LENGTH-1:
  - Ring mode: rptr→0, and wrap pulses with that dout_valid.
  - Single-pass mode: done=1 and rptr holds. Further strobes produce no dout_valid.
- Strobe not serviced: dout holds its last value and dout_valid=0.
- CLR in the same cycle as rd_en_ring: CLR wins and the strobe is dropped.
- Clearing EN mid-ring: the pointer freezes. Setting EN again resumes from rptr.
- A table write while running takes effect on the next read of that entry. A write in the same cycle as a read of the same entry returns the old data.
- LENGTH written below the current rptr+1: the next serviced strobe reads group rptr, then behaves as if rptr=LENGTH-1 (wrap or done).

Decomposition:
- Package freq_selector_pkg holds:
  - register offset constants;
  - CTRL bit positions;
  - STATUS field positions;
  - the OKAY response code.
- Sub-module freq_selector_regs holds the AXI4-Lite slave and register file, and drives the table write port plus the CTRL/LENGTH outputs.
- The top level holds the table RAM (simple dual-port, registered read) and the readout pointer logic.

Test Plan:
- Reset values: hold reset → dout=0, dout_valid=0, done=0. Read LENGTH → 256; read STATUS → 0.
- Ring wrap (LANES=2, LENGTH=3):
  - Stimulus: write entries 0..5 = 10..15, EN=1, then 4 strobes.
  - Required dout lanes {lane0,lane1}: {10,11}, {12,13}, {14,15}, {10,11}.
  - wrap pulses with the third valid.
- Single-pass (same table, MODE=1): 5 strobes → 3 dout_valid pulses. done=1 after the third. STATUS reads 0x0002_0002.
- CLR priority: strobe and CLR in the same cycle → no dout_valid, rptr=0. The next strobe yields {10,11}.
- Boundaries:
  - LENGTH=0 → each strobe repeats group 0.
  - WDATA write with WSTRB=0001 → table unchanged and WADDR unchanged.
  - Read of offset 0x1C → 0 with RRESP=OKAY.

Source files
------------

// File: rtl/freq_selector_pkg.sv
// Shared constants for the multi-lane frequency selector:
// register map, CTRL/STATUS bit layout and AXI response code.
package freq_selector_pkg;

    localparam int OFF_CTRL   = 'h00;
    localparam int OFF_LENGTH = 'h04;
    localparam int OFF_WADDR  = 'h08;
    localparam int OFF_WDATA  = 'h0C;
    localparam int OFF_STATUS = 'h10;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_CLR  = 2;

    localparam int ST_RUN  = 0;
    localparam int ST_DONE = 1;
    localparam int ST_RPTR = 16;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/freq_selector_regs.sv
// AXI4-Lite slave and register file; drives the table write
// port and the CTRL/LENGTH controls of the readout logic.
module freq_selector_regs
    import freq_selector_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int IDX_W  = 14,
    parameter int LANES  = 2,
    parameter int DEPTH  = 256,
    parameter int PW     = 8,
    parameter int AW     = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic              i_arvalid,
    output logic              o_arready,
    output logic [31:0]       o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rvalid,
    input  logic              i_rready,
    input  logic [PW-1:0]     i_rptr,
    input  logic              i_done,
    output logic              o_en,
    output logic              o_mode,
    output logic              o_clr,
    output logic [31:0]       o_len,
    output logic              o_tbl_we,
    output logic [AW-1:0]     o_tbl_addr,
    output logic [IDX_W-1:0]  o_tbl_data
);

    logic              r_awready, r_bvalid, r_arready, r_rvalid;
    logic              r_en, r_mode;
    logic [31:0]       r_len, r_rdata;
    logic [AW-1:0]     r_waddr;
    logic              w_wr, w_rd, w_tbl_ok;
    int                w_woff, w_roff;
    logic [AW-1:0]     w_waddr_nxt;
    logic [31:0]       w_ctrl, w_status, w_rmux;
    logic              w_unused;

    assign w_unused = ^{i_awaddr[1:0], i_araddr[1:0]};

    assign w_woff   = int'({i_awaddr[ADDR_W-1:2], 2'b00});
    assign w_roff   = int'({i_araddr[ADDR_W-1:2], 2'b00});
    assign w_wr     = r_awready & i_awvalid & i_wvalid;
    assign w_rd     = r_arready & i_arvalid;
    assign w_tbl_ok = (i_wstrb[1:0] == 2'b11);

    assign w_waddr_nxt = (r_waddr == AW'(DEPTH*LANES-1)) ?
                         '0 : r_waddr + AW'(1);

    assign o_clr = w_wr & (w_woff == OFF_CTRL) & i_wstrb[0]
                 & i_wdata[CTRL_CLR];
    assign o_tbl_we   = w_wr & (w_woff == OFF_WDATA) & w_tbl_ok;
    assign o_tbl_addr = r_waddr;
    assign o_tbl_data = i_wdata[IDX_W-1:0];

    always_comb begin
        w_ctrl            = '0;
        w_ctrl[CTRL_EN]   = r_en;
        w_ctrl[CTRL_MODE] = r_mode;
        w_status          = '0;
        w_status[ST_RUN]  = r_en & ~i_done;
        w_status[ST_DONE] = i_done;
        w_status[ST_RPTR +: 16] = 16'(i_rptr);
        w_rmux = '0;
        unique case (1'b1)
            (w_roff == OFF_CTRL):   w_rmux = w_ctrl;
            (w_roff == OFF_LENGTH): w_rmux = r_len;
            (w_roff == OFF_WADDR):  w_rmux = 32'(r_waddr);
            (w_roff == OFF_STATUS): w_rmux = w_status;
            default:                w_rmux = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_en      <= 1'b0;
            r_mode    <= 1'b0;
            r_len     <= 32'(DEPTH);
            r_waddr   <= '0;
        end else begin
            r_awready <= ~r_awready & i_awvalid & i_wvalid & ~r_bvalid;
            if (w_wr)          r_bvalid <= 1'b1;
            else if (i_bready) r_bvalid <= 1'b0;
            if (w_wr) begin
                unique case (1'b1)
                    (w_woff == OFF_CTRL): begin
                        if (i_wstrb[0]) begin
                            r_en   <= i_wdata[CTRL_EN];
                            r_mode <= i_wdata[CTRL_MODE];
                        end
                    end
                    (w_woff == OFF_LENGTH):
                        r_len <= apply_strb(r_len, i_wdata, i_wstrb);
                    (w_woff == OFF_WADDR):
                        r_waddr <= AW'(apply_strb(32'(r_waddr),
                                                  i_wdata, i_wstrb));
                    (w_woff == OFF_WDATA):
                        if (w_tbl_ok) r_waddr <= w_waddr_nxt;
                    default: ;
                endcase
            end
            r_arready <= ~r_arready & i_arvalid & ~r_rvalid;
            if (w_rd) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rmux;
            end else if (i_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_awready;
    assign o_bresp   = RESP_OKAY;
    assign o_bvalid  = r_bvalid;
    assign o_arready = r_arready;
    assign o_rdata   = r_rdata;
    assign o_rresp   = RESP_OKAY;
    assign o_rvalid  = r_rvalid;
    assign o_en      = r_en;
    assign o_mode    = r_mode;
    assign o_len     = r_len;

endmodule

// File: rtl/axi_freq_selector_mc.sv
// Multi-lane tone index selector: AXI-written table, one group
// of LANES indices emitted per rd_en_ring strobe (ring/single-pass).
module axi_freq_selector_mc
    import freq_selector_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int IDX_W = 14,
    parameter int LANES = 2,
    parameter int DEPTH = 256
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic                            rd_en_ring,
    output logic [LANES*IDX_W-1:0]          dout,
    output logic                            dout_valid,
    output logic [IDX_W-1:0]                dout_mon,
    output logic                            wrap,
    output logic                            done,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int AW  = $clog2(DEPTH*LANES);
    localparam int LNW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                         w_en, w_mode, w_clr, w_tbl_we;
    logic [31:0]                  w_len;
    logic [AW-1:0]                w_tbl_addr;
    logic [IDX_W-1:0]             w_tbl_data;
    logic [PW-1:0]                w_wgrp;
    logic [LNW-1:0]               w_wlane;
    logic [LW-1:0]                w_len_eff;
    logic                         w_last, w_fire, w_unused;
    logic [LANES-1:0][IDX_W-1:0]  r_mem [DEPTH];
    logic [LANES-1:0][IDX_W-1:0]  r_dout;
    logic [PW-1:0]                r_rptr;
    logic                         r_done, r_valid, r_wrap;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    freq_selector_regs #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .IDX_W  (IDX_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .PW     (PW),
        .AW     (AW)
    ) u_regs (
        .i_clk      (S_AXI_ACLK),
        .i_rst_n    (S_AXI_ARESETN),
        .i_awaddr   (S_AXI_AWADDR),
        .i_awvalid  (S_AXI_AWVALID),
        .o_awready  (S_AXI_AWREADY),
        .i_wdata    (S_AXI_WDATA),
        .i_wstrb    (S_AXI_WSTRB),
        .i_wvalid   (S_AXI_WVALID),
        .o_wready   (S_AXI_WREADY),
        .o_bresp    (S_AXI_BRESP),
        .o_bvalid   (S_AXI_BVALID),
        .i_bready   (S_AXI_BREADY),
        .i_araddr   (S_AXI_ARADDR),
        .i_arvalid  (S_AXI_ARVALID),
        .o_arready  (S_AXI_ARREADY),
        .o_rdata    (S_AXI_RDATA),
        .o_rresp    (S_AXI_RRESP),
        .o_rvalid   (S_AXI_RVALID),
        .i_rready   (S_AXI_RREADY),
        .i_rptr     (r_rptr),
        .i_done     (r_done),
        .o_en       (w_en),
        .o_mode     (w_mode),
        .o_clr      (w_clr),
        .o_len      (w_len),
        .o_tbl_we   (w_tbl_we),
        .o_tbl_addr (w_tbl_addr),
        .o_tbl_data (w_tbl_data)
    );

    assign w_wgrp  = PW'(w_tbl_addr / AW'(LANES));
    assign w_wlane = LNW'(w_tbl_addr % AW'(LANES));

    // Table contents are not reset; the read register gives old-data
    // semantics when a write and a read hit the same entry.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_tbl_we) r_mem[w_wgrp][w_wlane] <= w_tbl_data;
    end

    always_comb begin
        w_len_eff = LW'(DEPTH);
        if (w_len == 32'd0)              w_len_eff = LW'(1);
        else if (w_len < 32'(DEPTH))     w_len_eff = LW'(w_len);
    end

    // ">=" also covers LENGTH shrunk below the current pointer.
    assign w_last = ({1'b0, r_rptr} + LW'(1)) >= w_len_eff;
    assign w_fire = rd_en_ring & w_en & ~r_done & ~w_clr;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_dout  <= '0;
            r_rptr  <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_valid <= w_fire;
            r_wrap  <= w_fire & w_last & ~w_mode;
            if (w_fire) r_dout <= r_mem[r_rptr];
            if (w_clr) begin
                r_rptr <= '0;
                r_done <= 1'b0;
            end else if (w_fire) begin
                if (!w_last)     r_rptr <= r_rptr + PW'(1);
                else if (w_mode) r_done <= 1'b1;
                else             r_rptr <= '0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign dout_mon   = r_dout[0];
    assign wrap       = r_wrap;
    assign done       = r_done;

endmodule

// File: tb/tb_axi_freq_selector_mc.sv
// Self-checking bench for axi_freq_selector_mc: directed scenarios
// plus randomized strobes against a behavioural model.
module tb_axi_freq_selector_mc;

    localparam int IDX_W = 14;
    localparam int LANES = 2;
    localparam int DEPTH = 256;
    localparam int NENT  = DEPTH * LANES;
    localparam int DW    = LANES * IDX_W;

    logic          clk, rst_n, rd_en_ring;
    logic [DW-1:0] dout;
    logic          dout_valid, wrap, done;
    logic [IDX_W-1:0] dout_mon;
    logic [4:0]    awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [IDX_W-1:0] m_tbl [NENT];
    bit               m_en, m_mode, m_done;
    int unsigned      m_len, m_waddr, m_rptr;
    logic [DW-1:0]    m_dout;

    axi_freq_selector_mc #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .IDX_W (IDX_W),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .rd_en_ring    (rd_en_ring),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_mon      (dout_mon),
        .wrap          (wrap),
        .done          (done),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int unsigned merge(input int unsigned o,
                                          input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    task automatic m_apply_write(input logic [4:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
        case (a)
            5'h00: if (s[0]) begin
                m_en = d[0];
                m_mode = d[1];
                if (d[2]) begin
                    m_rptr = 0;
                    m_done = 0;
                end
            end
            5'h04: m_len = merge(m_len, d, s);
            5'h08: m_waddr = merge(m_waddr, d, s) % NENT;
            5'h0C: if (s[1:0] == 2'b11) begin
                m_tbl[m_waddr] = d[IDX_W-1:0];
                m_waddr = (m_waddr + 1) % NENT;
            end
            default: ;
        endcase
    endtask

    // One strobe opportunity as the specification describes it.
    task automatic m_step(input bit rd, output bit v, output bit w,
                          output logic [DW-1:0] d);
        int unsigned l;
        v = 0;
        w = 0;
        if (rd && m_en && !m_done) begin
            v = 1;
            for (int k = 0; k < LANES; k++)
                m_dout[k*IDX_W +: IDX_W] = m_tbl[m_rptr*LANES + k];
            l = (m_len == 0) ? 1 : ((m_len > DEPTH) ? DEPTH : m_len);
            if (m_rptr + 1 >= l) begin
                if (m_mode) m_done = 1;
                else begin
                    m_rptr = 0;
                    w = 1;
                end
            end else begin
                m_rptr++;
            end
        end
        d = m_dout;
    endtask

    function automatic logic [31:0] m_status();
        return {16'(m_rptr), 14'd0, m_done, m_en & ~m_done};
    endfunction

    task automatic step(input bit rd, output bit v, output bit w,
                        output logic [DW-1:0] d);
        rd_en_ring = rd;
        @(posedge clk);
        #1;
        rd_en_ring = 1'b0;
        m_step(rd, v, w, d);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit strobe,
                             output bit obs_v);
        bit got;
        @(posedge clk);
        #1;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (awready && wready) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL aw_timeout addr=%h awready=%b required 1", a, awready);
        end
        if (strobe) rd_en_ring = 1'b1;
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; rd_en_ring = 1'b0;
        obs_v = dout_valid;
        if (got) m_apply_write(a, d, s);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) got = 1;
            else @(negedge clk);
        end
        checks++;
        if (!got || bresp !== 2'b00) begin
            errors++;
            $display("FAIL bresp addr=%h bvalid=%b bresp=%b required 1/00", a, bvalid, bresp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                            output logic [1:0] r);
        bit got;
        @(posedge clk);
        #1;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (arready) got = 1;
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ar_timeout addr=%h rvalid=%b required 1", a, rvalid);
        end
        d = rdata;
        r = rresp;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dout !== '0 || dout_valid !== 0 || done !== 0 || wrap !== 0 ||
            awready !== 0 || wready !== 0 || bvalid !== 0 ||
            arready !== 0 || rvalid !== 0) begin
            errors++;
            $display("FAIL reset_out dout=%h v=%b done=%b wrap=%b aw=%b b=%b ar=%b r=%b required all 0",
                     dout, dout_valid, done, wrap, awready, bvalid, arready, rvalid);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        axi_read(5'h04, d, r);
        checks++;
        if (d !== 32'd256) begin
            errors++;
            $display("FAIL reset_length got=%0d required 256", d);
        end
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_status got=%h required 0", d);
        end
    endtask

    task automatic load_table();
        bit x;
        axi_write(5'h08, 32'd0, 4'hF, 0, x);
        for (int i = 0; i < 6; i++)
            axi_write(5'h0C, 32'(10 + i), 4'hF, 0, x);
    endtask

    task automatic test_ring();
        bit x, v, w;
        logic [DW-1:0] d;
        int wraps;
        wraps = 0;
        load_table();
        axi_write(5'h04, 32'd3, 4'hF, 0, x);
        axi_write(5'h00, 32'h1, 4'hF, 0, x);
        for (int i = 0; i < 4; i++) begin
            step(1, v, w, d);
            if (wrap === 1'b1) wraps++;
            checks++;
            if (dout_valid !== v || wrap !== w || dout !== d ||
                dout_mon !== d[IDX_W-1:0]) begin
                errors++;
                $display("FAIL ring[%0d] v=%b wrap=%b dout=%h mon=%h required %b %b %h",
                         i, dout_valid, wrap, dout, dout_mon, v, w, d);
            end
            if (i == 2) begin
                checks++;
                if (dout !== {14'd15, 14'd14} || wrap !== 1'b1) begin
                    errors++;
                    $display("FAIL ring_third dout=%h wrap=%b required %h 1",
                             dout, wrap, {14'd15, 14'd14});
                end
            end
        end
        checks++;
        if (wraps != 1 || dout !== {14'd11, 14'd10}) begin
            errors++;
            $display("FAIL ring_final wraps=%0d dout=%h required 1 %h",
                     wraps, dout, {14'd11, 14'd10});
        end
    endtask

    task automatic test_single_pass();
        bit x, v, w;
        logic [DW-1:0] d;
        logic [31:0] s;
        logic [1:0]  r;
        int nv;
        nv = 0;
        axi_write(5'h00, 32'h7, 4'hF, 0, x);
        for (int i = 0; i < 5; i++) begin
            step(1, v, w, d);
            if (dout_valid === 1'b1) nv++;
            checks++;
            if (dout_valid !== v || wrap !== w || dout !== d ||
                done !== m_done) begin
                errors++;
                $display("FAIL single[%0d] v=%b wrap=%b dout=%h done=%b required %b %b %h %b",
                         i, dout_valid, wrap, dout, done, v, w, d, m_done);
            end
        end
        axi_read(5'h10, s, r);
        checks++;
        if (nv != 3 || done !== 1'b1 || s !== 32'h0002_0002) begin
            errors++;
            $display("FAIL single_end valids=%0d done=%b status=%h required 3 1 00020002",
                     nv, done, s);
        end
    endtask

    task automatic test_clr_priority();
        bit x, ov, v, w;
        logic [DW-1:0] d;
        logic [31:0] s;
        logic [1:0]  r;
        axi_write(5'h00, 32'h5, 4'hF, 0, x);
        step(1, v, w, d);
        axi_write(5'h00, 32'h5, 4'hF, 1, ov);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL clr_strobe dout_valid=%b required 0", ov);
        end
        axi_read(5'h10, s, r);
        checks++;
        if (s !== 32'h0000_0001 || s !== m_status()) begin
            errors++;
            $display("FAIL clr_status got=%h required 00000001", s);
        end
        step(1, v, w, d);
        checks++;
        if (dout_valid !== 1'b1 || dout !== {14'd11, 14'd10} || dout !== d) begin
            errors++;
            $display("FAIL clr_next v=%b dout=%h required 1 %h",
                     dout_valid, dout, {14'd11, 14'd10});
        end
    endtask

    task automatic test_length0();
        bit x, v, w;
        logic [DW-1:0] d;
        axi_write(5'h00, 32'h5, 4'hF, 0, x);
        axi_write(5'h04, 32'd0, 4'hF, 0, x);
        for (int i = 0; i < 3; i++) begin
            step(1, v, w, d);
            checks++;
            if (dout_valid !== 1'b1 || wrap !== 1'b1 ||
                dout !== {14'd11, 14'd10} || dout !== d || wrap !== w) begin
                errors++;
                $display("FAIL len0[%0d] v=%b wrap=%b dout=%h required 1 1 %h",
                         i, dout_valid, wrap, dout, {14'd11, 14'd10});
            end
        end
    endtask

    task automatic test_wstrb_drop();
        bit x, v, w;
        logic [DW-1:0] d;
        logic [31:0] rd;
        logic [1:0]  r;
        axi_write(5'h08, 32'd0, 4'hF, 0, x);
        axi_write(5'h0C, 32'h3FFF, 4'b0001, 0, x);
        axi_read(5'h08, rd, r);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL wstrb_waddr got=%0d required 0", rd);
        end
        step(1, v, w, d);
        checks++;
        if (dout !== {14'd11, 14'd10} || dout !== d) begin
            errors++;
            $display("FAIL wstrb_table dout=%h required %h", dout, {14'd11, 14'd10});
        end
        axi_read(5'h0C, rd, r);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL wdata_read got=%h required 0", rd);
        end
    endtask

    task automatic test_unmapped();
        bit x;
        logic [31:0] rd;
        logic [1:0]  r;
        axi_read(5'h1C, rd, r);
        checks++;
        if (rd !== 32'd0 || r !== 2'b00) begin
            errors++;
            $display("FAIL unmapped_1c data=%h resp=%b required 0 00", rd, r);
        end
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, 0, x);
        axi_read(5'h14, rd, r);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_14 data=%h required 0", rd);
        end
        axi_read(5'h00, rd, r);
        checks++;
        if (rd !== {30'd0, m_mode, m_en}) begin
            errors++;
            $display("FAIL ctrl_read data=%h required %h", rd, {30'd0, m_mode, m_en});
        end
    endtask

    task automatic test_en_pause();
        bit x, v, w;
        logic [DW-1:0] d;
        logic [31:0] cv [3];
        cv[0] = 32'h5; cv[1] = 32'h0; cv[2] = 32'h1;
        axi_write(5'h04, 32'd3, 4'hF, 0, x);
        for (int p = 0; p < 3; p++) begin
            axi_write(5'h00, cv[p], 4'hF, 0, x);
            for (int i = 0; i < 2; i++) begin
                step(1, v, w, d);
                checks++;
                if (dout_valid !== v || wrap !== w || dout !== d) begin
                    errors++;
                    $display("FAIL en_pause[%0d.%0d] v=%b wrap=%b dout=%h required %b %b %h",
                             p, i, dout_valid, wrap, dout, v, w, d);
                end
            end
        end
    endtask

    task automatic test_random();
        bit x, v, w, rd;
        logic [DW-1:0] d;
        logic [31:0] s;
        logic [1:0]  r;
        int unsigned len;
        for (int round = 0; round < 4; round++) begin
            axi_write(5'h00, 32'h4, 4'hF, 0, x);
            len = $urandom_range(1, 8);
            if (round == 3) len = 300;
            axi_write(5'h04, len, 4'hF, 0, x);
            axi_write(5'h08, 32'd0, 4'hF, 0, x);
            for (int i = 0; i < 16; i++)
                axi_write(5'h0C, $urandom, 4'hF, 0, x);
            axi_write(5'h00, 32'(1 + 2 * (round % 2)), 4'hF, 0, x);
            for (int c = 0; c < 40; c++) begin
                rd = ($urandom % 4) != 0;
                if (round == 3 && rd && c >= 8) rd = 0;
                step(rd, v, w, d);
                checks++;
                if (dout_valid !== v || wrap !== w || dout !== d ||
                    done !== m_done) begin
                    errors++;
                    $display("FAIL rand[%0d.%0d] v=%b wrap=%b dout=%h done=%b required %b %b %h %b",
                             round, c, dout_valid, wrap, dout, done, v, w, d, m_done);
                end
            end
            axi_read(5'h10, s, r);
            checks++;
            if (s !== m_status()) begin
                errors++;
                $display("FAIL rand_status[%0d] got=%h required %h", round, s, m_status());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; rd_en_ring = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        m_en = 0; m_mode = 0; m_done = 0;
        m_len = DEPTH; m_waddr = 0; m_rptr = 0; m_dout = '0;
        for (int i = 0; i < NENT; i++) m_tbl[i] = '0;
        test_reset();
        test_ring();
        test_single_pass();
        test_clr_priority();
        test_length0();
        test_wstrb_drop();
        test_unmapped();
        test_en_pause();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
